// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit: stall-level encodings,
// the NOP instruction word loaded into flushed stages, and FSM states.
package pipe_pkg;

  // Stall level driven on flag_hold; each step freezes one more pipeline register.
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StIrq   = 2'd2
  } state_e;

  // Larger of two stall levels; encodings are ordered by severity.
  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_timer.sv
// Saturating bus-hold cycle counter with a sticky timeout flag.
// Only instantiated when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl_timer #(
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_arstn,
  input  logic i_hold_bus,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_TIMEOUT);

  logic [CntW-1:0] r_cnt;
  logic            r_timeout;

  // Count consecutive bus-hold cycles, clear on any gap, stop at the limit.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_cnt <= '0;
    end else if (!i_hold_bus) begin
      r_cnt <= '0;
    end else if (r_cnt != CntMax) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Flag rises the cycle after the count hits the limit and holds until reset.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_timeout <= 1'b0;
    end else if (r_cnt == CntMax) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates jump/interrupt redirects against stall
// sources and drives flush, stall level and PC redirect for the 3-stage core.
// Optional bus-hold timeout is enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_arstn,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_id_req_i,
  input  logic        hold_ex_req_i,
  input  logic        hold_bus_req_i,
  input  logic        irq_req_i,
  input  logic [31:0] irq_addr_i,
  output logic        irq_ack_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        flag_flush,
  output logic [2:0]  flag_hold,
  output logic        hold_timeout_o
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  // Extension cycles after the redirect cycle itself. The interrupt path spends
  // one extra cycle in StIrq, so its FLUSH leg is one shorter.
  localparam logic [CntW-1:0] CntJump = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] CntIrq  = CntW'(FLUSH_CYCLES - 2);

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic        w_jump_acc;
  logic        w_irq_take;
  logic        w_flush;
  logic [2:0]  w_hold;
  logic [31:0] w_addr;
  logic        w_timeout;

  // Jump wins over interrupt; interrupt needs a quiet pipeline in IDLE.
  always_comb begin
    w_jump_acc = jump_req_i & ~hold_ex_req_i;
    w_irq_take = (r_state == StIdle) & irq_req_i & ~w_jump_acc &
                 ~hold_id_req_i & ~hold_ex_req_i & ~hold_bus_req_i;
    w_flush    = w_jump_acc | w_irq_take | (r_state != StIdle);
    w_addr     = '0;
    if (w_jump_acc) begin
      w_addr = jump_addr_i;
    end else if (w_irq_take) begin
      w_addr = irq_addr_i;
    end
  end

  // Stall level is the maximum of active sources; the load-use hold is moot
  // while the hazard instruction is being flushed.
  always_comb begin
    w_hold = HOLD_NONE;
    if (hold_id_req_i && !w_flush) begin
      w_hold = hold_max(w_hold, HOLD_IF);
    end
    if (hold_ex_req_i) begin
      w_hold = hold_max(w_hold, HOLD_ID);
    end
    if (hold_bus_req_i) begin
      w_hold = hold_max(w_hold, HOLD_ID);
    end
  end

  // Next-state and flush-extension counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_jump_acc) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = StFlush;
        w_cnt_nxt   = CntJump;
      end else begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          if (w_irq_take && (FLUSH_CYCLES > 1)) begin
            w_state_nxt = StIrq;
          end
        end
        StIrq: begin
          if (FLUSH_CYCLES > 2) begin
            w_state_nxt = StFlush;
            w_cnt_nxt   = CntIrq;
          end else begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
          end
        end
        StFlush: begin
          if (r_cnt <= CntW'(1)) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CntW'(1);
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register; reset drops any flush in progress.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  pipe_ctrl_timer #(
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) u_timer (
    .sys_clk    (sys_clk),
    .sys_arstn  (sys_arstn),
    .i_hold_bus (hold_bus_req_i),
    .o_timeout  (w_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (HOLD_TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  // Combinational paths are gated so every output reads 0 during reset.
  assign jump_flag_o    = sys_arstn & (w_jump_acc | w_irq_take);
  assign jump_addr_o    = sys_arstn ? w_addr : 32'h0;
  assign irq_ack_o      = sys_arstn & w_irq_take;
  assign flag_flush     = sys_arstn & w_flush;
  assign flag_hold      = sys_arstn ? w_hold : HOLD_NONE;
  assign hold_timeout_o = sys_arstn & w_timeout;

endmodule
